regfile_bank: RTL and testbench

- Parametrised register-file bank built from enabled, resettable storage entries.
- Generational successor to the single-register primitive: one register becomes `depth` entries of `width` bits, each resetting to `init`.
- Adds one write port, two combinational read ports, optional write-to-read bypass, a per-entry valid bitmap and a valid-entry counter.
- Sits below the generated register-file wrappers in the register_file experiments; it replaces hand-instanced per-register cells.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_bank_entry.sv | 31 +++
 rtl/regfile_bank.sv | 98 +++++++++
 tb/tb_regfile_bank.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared helpers for the register-file bank.
// Width derivations and the default reset value.
package regfile_pkg;

  localparam int INIT_DEFAULT = 0;

  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int aw_of(input int d);
    return (clog2(d) < 1) ? 1 : clog2(d);
  endfunction

  function automatic int cw_of(input int d);
    return clog2(d + 1);
  endfunction

endpackage

// File: rtl/regfile_bank_entry.sv
// One storage entry: enabled register with sync
// active-low reset to init and selectable edge.
module rf_entry #(
  parameter int              width       = 16,
  parameter logic [width-1:0] init       = '0,
  parameter bit              clk_posedge = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] data_q, data_d;

  always_comb data_d = en ? d : data_q;

  if (clk_posedge) begin : g_pos
    always_ff @(posedge clk)
      if (!rst_n) data_q <= init;
      else        data_q <= data_d;
  end else begin : g_neg
    always_ff @(negedge clk)
      if (!rst_n) data_q <= init;
      else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/regfile_bank.sv
// Register-file bank: depth entries, one write port,
// two combinational read ports, valid map and count.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int               width       = 16,
  parameter int               depth       = 8,
  parameter logic [width-1:0] init        = width'(INIT_DEFAULT),
  parameter bit               clk_posedge = 1'b1,
  parameter bit               bypass      = 1'b0,
  localparam int              AW          = aw_of(depth),
  localparam int              CW          = cw_of(depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             clr,
  input  logic [AW-1:0]    raddr0,
  output logic [width-1:0] rdata0,
  output logic             rvalid0,
  input  logic [AW-1:0]    raddr1,
  output logic [width-1:0] rdata1,
  output logic             rvalid1,
  output logic [CW-1:0]    valid_count
);

  localparam logic [AW:0] LIM = (AW + 1)'(depth);

  logic [width-1:0] ent [depth];
  logic [depth-1:0] wsel;
  logic [depth-1:0] valid_q, valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             w_ok;

  assign w_ok = wen && ({1'b0, waddr} < LIM);

  // Clear wipes the map first so a same-cycle write survives.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < depth; i++)
      wsel[i] = w_ok && (waddr == AW'(i));
    valid_d = (clr ? '0 : valid_q) | wsel;
    cnt_d = '0;
    for (int i = 0; i < depth; i++)
      cnt_d = cnt_d + CW'(valid_d[i]);
  end

  for (genvar i = 0; i < depth; i++) begin : g_ent
    rf_entry #(
      .width      (width),
      .init       (init),
      .clk_posedge(clk_posedge)
    ) u_entry (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (wsel[i]),
      .d    (wdata),
      .q    (ent[i])
    );
  end

  if (clk_posedge) begin : g_pos
    always_ff @(posedge clk)
      if (!rst_n) begin
        valid_q <= '0;
        cnt_q   <= '0;
      end else begin
        valid_q <= valid_d;
        cnt_q   <= cnt_d;
      end
  end else begin : g_neg
    always_ff @(negedge clk)
      if (!rst_n) begin
        valid_q <= '0;
        cnt_q   <= '0;
      end else begin
        valid_q <= valid_d;
        cnt_q   <= cnt_d;
      end
  end

  function automatic logic [width:0] rd(input logic [AW-1:0] a);
    logic [width:0] r;
    r = {1'b0, init};
    if ({1'b0, a} < LIM)
      if (valid_q[a]) r = {1'b1, ent[a]};
    if (bypass && w_ok && (waddr == a))
      r = {1'b1, wdata};
    return r;
  endfunction

  assign {rvalid0, rdata0} = rd(raddr0);
  assign {rvalid1, rdata1} = rd(raddr1);
  assign valid_count = cnt_q;

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench: four bank variants driven in lockstep
// (bypass, no bypass, depth 6, negedge clock).
module tb_regfile_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0;
  logic [2:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic        clr = 1'b0;
  logic [2:0]  raddr0 = '0;
  logic [2:0]  raddr1 = '0;

  logic [15:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic [15:0] c_rd0, c_rd1, d_rd0, d_rd1;
  logic        a_rv0, a_rv1, b_rv0, b_rv1;
  logic        c_rv0, c_rv1, d_rv0, d_rv1;
  logic [3:0]  a_cnt, b_cnt, d_cnt;
  logic [2:0]  c_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_bank #(.width(16), .depth(8), .init(16'h00A5),
    .clk_posedge(1'b1), .bypass(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr),
    .wdata(wdata), .clr(clr),
    .raddr0(raddr0), .rdata0(a_rd0), .rvalid0(a_rv0),
    .raddr1(raddr1), .rdata1(a_rd1), .rvalid1(a_rv1),
    .valid_count(a_cnt));

  regfile_bank #(.width(16), .depth(8), .init(16'h00A5),
    .clk_posedge(1'b1), .bypass(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr),
    .wdata(wdata), .clr(clr),
    .raddr0(raddr0), .rdata0(b_rd0), .rvalid0(b_rv0),
    .raddr1(raddr1), .rdata1(b_rd1), .rvalid1(b_rv1),
    .valid_count(b_cnt));

  regfile_bank #(.width(16), .depth(6), .init(16'h00A5),
    .clk_posedge(1'b1), .bypass(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr),
    .wdata(wdata), .clr(clr),
    .raddr0(raddr0), .rdata0(c_rd0), .rvalid0(c_rv0),
    .raddr1(raddr1), .rdata1(c_rd1), .rvalid1(c_rv1),
    .valid_count(c_cnt));

  regfile_bank #(.width(16), .depth(8), .init(16'h00A5),
    .clk_posedge(1'b0), .bypass(1'b0)) u_d (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr),
    .wdata(wdata), .clr(clr),
    .raddr0(raddr0), .rdata0(d_rd0), .rvalid0(d_rv0),
    .raddr1(raddr1), .rdata1(d_rd1), .rvalid1(d_rv1),
    .valid_count(d_cnt));

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      raddr0 = 3'(i);
      raddr1 = 3'(7 - i);
      #1;
      check($sformatf("rst_rd0_%0d", i), b_rd0, 16'h00A5);
      check($sformatf("rst_rv0_%0d", i), b_rv0, 1'b0);
      check($sformatf("rst_rd1_%0d", i), b_rd1, 16'h00A5);
    end
    check("rst_cnt", b_cnt, 4'd0);

    // write 3, bypass and non-bypass views
    wen = 1'b1; waddr = 3'd3; wdata = 16'h1234;
    raddr0 = 3'd3; raddr1 = 3'd3;
    #1;
    check("byp_w3_rd", a_rd0, 16'h1234);
    check("byp_w3_rv", a_rv0, 1'b1);
    check("nob_w3_rd", b_rd0, 16'h00A5);
    check("nob_w3_rv", b_rv0, 1'b0);
    step();
    wen = 1'b0;
    #1;
    check("w3_rd0", b_rd0, 16'h1234);
    check("w3_rd1", b_rd1, 16'h1234);
    check("w3_rv1", b_rv1, 1'b1);
    check("w3_cnt", b_cnt, 4'd1);
    wen = 1'b1; wdata = 16'hBEEF;
    step();
    wen = 1'b0;
    #1;
    check("rw3_rd", b_rd0, 16'hBEEF);
    check("rw3_cnt", b_cnt, 4'd1);

    // bypass on addr 5; negedge variant updates mid-cycle
    wen = 1'b1; waddr = 3'd5; wdata = 16'h0F0F;
    raddr0 = 3'd5;
    #1;
    check("byp5_rd", a_rd0, 16'h0F0F);
    check("byp5_rv", a_rv0, 1'b1);
    check("nob5_rd", b_rd0, 16'h00A5);
    check("nob5_rv", b_rv0, 1'b0);
    #5;
    check("neg5_rd", d_rd0, 16'h0F0F);
    check("neg5_cnt", d_cnt, 4'd2);
    check("pos5_cnt", b_cnt, 4'd1);
    step();

    // fill all, then clear with write
    for (int i = 0; i < 8; i++) begin
      waddr = 3'(i); wdata = 16'h1000 + 16'(i);
      step();
    end
    wen = 1'b0;
    #1;
    check("fill_cnt8", b_cnt, 4'd8);
    check("fill_cnt6", c_cnt, 3'd6);
    clr = 1'b1; wen = 1'b1; waddr = 3'd2; wdata = 16'h7777;
    raddr0 = 3'd2; raddr1 = 3'd0;
    #1;
    check("clr_byp_rd", a_rd0, 16'h7777);
    step();
    clr = 1'b0; wen = 1'b0;
    #1;
    check("clr_cnt", b_cnt, 4'd1);
    check("clr_rd2", b_rd0, 16'h7777);
    check("clr_rv2", b_rv0, 1'b1);
    check("clr_rd0", b_rd1, 16'h00A5);
    check("clr_rv0", b_rv1, 1'b0);
    check("clr_held0", u_b.ent[0], 16'h1000);
    check("clr_cnt_c", c_cnt, 3'd1);

    // out-of-range on depth 6
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; wen = 1'b1; waddr = 3'd7; wdata = 16'h9999;
    step();
    wen = 1'b0; raddr0 = 3'd6; raddr1 = 3'd7;
    #1;
    check("oor_cnt", c_cnt, 3'd0);
    check("oor_rd6", c_rd0, 16'h00A5);
    check("oor_rv6", c_rv0, 1'b0);
    check("oor_rd7", c_rd1, 16'h00A5);
    check("in7_rd", b_rd1, 16'h9999);
    check("in7_cnt", b_cnt, 4'd1);
    step();

    // reset beats write; negedge variant resets first
    rst_n = 1'b0; wen = 1'b1; waddr = 3'd1; wdata = 16'h5555;
    #6;
    check("rstw_neg_cnt", d_cnt, 4'd0);
    check("rstw_pos_cnt", b_cnt, 4'd1);
    step();
    rst_n = 1'b1; wen = 1'b0; raddr0 = 3'd1;
    #1;
    check("rstw_rd", b_rd0, 16'h00A5);
    check("rstw_rv", b_rv0, 1'b0);
    check("rstw_cnt", b_cnt, 4'd0);
    check("rstw_ent", u_b.ent[1], 16'h00A5);
    check("rstw_neg_rd", d_rd0, 16'h00A5);

    // back-to-back same address
    wen = 1'b1; waddr = 3'd4; wdata = 16'hAAAA;
    step();
    wdata = 16'hBBBB;
    #1;
    check("b2b_cnt1", b_cnt, 4'd1);
    step();
    wen = 1'b0; raddr0 = 3'd4;
    #1;
    check("b2b_rd", b_rd0, 16'hBBBB);
    check("b2b_cnt2", b_cnt, 4'd1);
    check("b2b_neg_rd", d_rd0, 16'hBBBB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
